// File: rtl/mux_21_pkg.sv
// Shared definitions for the 2:1 mux select arbiter: FSM states, select
// encodings and default sizing for the burst hold limit.
package mux_21_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   localparam int DEF_MAX_BEATS = 16;
   localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/mux_21_arb_hold_cnt.sv
// Saturating beat counter for the current burst; flags the beat on which the
// hold limit is reached so the arbiter can force a release.
module hold_cnt
   import mux_21_pkg::*;
#(
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BEATS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment; stop at the limit so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/mux_21_arb.sv
// Round-robin burst arbiter producing a registered select for the 2:1 mux
// (requester 0 = input a, requester 1 = input b) plus per-requester grants.
module mux_21_arb
   import mux_21_pkg::*;
#(
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic last0,
   input  logic last1,
   output logic gnt0,
   output logic gnt1,
   output logic sel,
   output logic busy
);

   state_e state_q;
   state_e state_d;
   logic   sel_q;
   logic   sel_d;
   logic   last_srv_q;
   logic   last_srv_d;

   logic beat;
   logic arbitrate;
   logic pick_b;
   logic cnt_clr;
   logic cnt_inc;
   logic cnt_hit;

   hold_cnt #(
      .MAX_BEATS (MAX_BEATS),
      .CNT_W     (CNT_W)
   ) u_hold_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .hit (cnt_hit)
   );

   // IDLE always arbitrates; an owner arbitrates on the edge it releases, so
   // the next grant lands with no idle bubble between bursts.
   always_comb begin
      beat       = 1'b0;
      arbitrate  = 1'b1;
      state_d    = state_q;
      sel_d      = sel_q;
      last_srv_d = last_srv_q;
      cnt_clr    = 1'b0;

      case (state_q)
         GRANT0: begin
            beat      = req0;
            arbitrate = !req0 || last0 || cnt_hit;
         end
         GRANT1: begin
            beat      = req1;
            arbitrate = !req1 || last1 || cnt_hit;
         end
         default: begin
            arbitrate = 1'b1;
         end
      endcase

      pick_b = req1 && (!req0 || (last_srv_q == SEL_A));

      if (arbitrate) begin
         if (req0 || req1) begin
            state_d    = pick_b ? GRANT1 : GRANT0;
            sel_d      = pick_b ? SEL_B : SEL_A;
            last_srv_d = pick_b;
            cnt_clr    = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
   end

   assign cnt_inc = beat && !arbitrate;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= SEL_A;
         last_srv_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_srv_q <= last_srv_d;
      end
   end

   assign gnt0 = (state_q == GRANT0);
   assign gnt1 = (state_q == GRANT1);
   assign sel  = sel_q;
   assign busy = gnt0 || gnt1;

endmodule

// File: tb/tb_mux_21_arb.sv
// Self-checking bench for mux_21_arb: directed scenarios plus random traffic,
// all compared against a burst-level ownership model.
module tb_mux_21_arb;

   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst, req0, req1, last0, last1;
   logic gnt0, gnt1, sel, busy;

   int errors = 0;
   int checks = 0;

   // Model state: owner (-1 idle), beats done in burst, last served, select.
   int mOwner = -1;
   int mBeats = 0;
   int mLast  = 1;
   int mSel   = 0;

   always #5 clk = ~clk;

   mux_21_arb #(
      .MAX_BEATS (MAXB),
      .CNT_W     (5)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req0  (req0),
      .req1  (req1),
      .last0 (last0),
      .last1 (last1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .sel   (sel),
      .busy  (busy)
   );

   function automatic logic [3:0] expVec();
      logic [3:0] v;
      v[3] = (mOwner == 0);
      v[2] = (mOwner == 1);
      v[1] = (mSel == 1);
      v[0] = (mOwner != -1);
      return v;
   endfunction

   task automatic modelStep();
      bit r[2];
      bit l[2];
      bit rel;
      int nxt;
      r[0] = req0;  r[1] = req1;
      l[0] = last0; l[1] = last1;
      if (rst) begin
         mOwner = -1; mBeats = 0; mLast = 1; mSel = 0;
         return;
      end
      rel = 1'b1;
      if (mOwner >= 0) begin
         rel = !r[mOwner] || l[mOwner] || (mBeats + 1 == MAXB);
         if (!rel) mBeats++;
      end
      if (rel) begin
         if (r[0] && r[1]) nxt = 1 - mLast;
         else if (r[0])    nxt = 0;
         else if (r[1])    nxt = 1;
         else              nxt = -1;
         mOwner = nxt;
         if (nxt >= 0) begin
            mBeats = 0; mLast = nxt; mSel = nxt;
         end
      end
   endtask

   task automatic drive(input logic rs, input logic r0, input logic r1,
                        input logic l0, input logic l1);
      rst = rs; req0 = r0; req1 = r1; last0 = l0; last1 = l1;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_state got=%b want=0000", {gnt0, gnt1, sel, busy});
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0);
         checks++;
         if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_hold[%0d] got=%b want=0000", i, {gnt0, gnt1, sel, busy});
         end
      end
   endtask

   task automatic test_tie_start();
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL tie_first got=%b want=1001", {gnt0, gnt1, sel, busy});
      end
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 1, 1, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0111) begin
         errors++;
         $display("[TB] FAIL tie_handover got=%b want=0111", {gnt0, gnt1, sel, busy});
      end
   endtask

   task automatic test_forced_release();
      int held;
      held = 0;
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 1, 0, 0);
         if (gnt0 && i < 5) held++;
         checks++;
         if ({gnt0, gnt1, sel, busy} !== expVec()) begin
            errors++;
            $display("[TB] FAIL forced[%0d] got=%b want=%b", i, {gnt0, gnt1, sel, busy}, expVec());
         end
      end
      checks++;
      if (held !== MAXB) begin
         errors++;
         $display("[TB] FAIL forced_len got=%0d want=%0d", held, MAXB);
      end
   endtask

   task automatic test_lone_regrant();
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 0, (i % 2 == 0), 0);
         checks++;
         if ({gnt0, gnt1, sel, busy} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL lone[%0d] got=%b want=1001", i, {gnt0, gnt1, sel, busy});
         end
      end
      // A freshly cleared count must allow a full burst before the handover.
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 1, 0, 0);
         checks++;
         if ({gnt0, gnt1, sel, busy} !== expVec()) begin
            errors++;
            $display("[TB] FAIL lone_tail[%0d] got=%b want=%b", i, {gnt0, gnt1, sel, busy}, expVec());
         end
      end
   endtask

   task automatic test_request_drop();
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL drop_idle got=%b want=0010", {gnt0, gnt1, sel, busy});
      end
      drive(0, 0, 0, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL drop_hold got=%b want=0010", {gnt0, gnt1, sel, busy});
      end
   endtask

   task automatic test_mid_reset();
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(1, 0, 1, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL midrst_clear got=%b want=0000", {gnt0, gnt1, sel, busy});
      end
      drive(0, 0, 1, 0, 0);
      checks++;
      if ({gnt0, gnt1, sel, busy} !== 4'b0111) begin
         errors++;
         $display("[TB] FAIL midrst_regrant got=%b want=0111", {gnt0, gnt1, sel, busy});
      end
   endtask

   task automatic test_random();
      logic r0, r1, l0, l1, rs;
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         r0 = ($urandom_range(0, 9) < 7);
         r1 = ($urandom_range(0, 9) < 7);
         l0 = (mOwner == 0) && r0 && ($urandom_range(0, 3) == 0);
         l1 = (mOwner == 1) && r1 && ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 99) < 2);
         drive(rs, r0, r1, l0, l1);
         checks++;
         if ({gnt0, gnt1, sel, busy} !== expVec() || (gnt0 && gnt1)) begin
            errors++;
            $display("[TB] FAIL random[%0d] got=%b want=%b", i, {gnt0, gnt1, sel, busy}, expVec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
      test_reset();
      test_tie_start();
      test_forced_release();
      test_lone_regrant();
      test_request_drop();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
